// File: rtl/l2_llc_rsp_stub_if.sv
// Request/response channel pair between an L2 (master) and its home node (slave).
interface l2_llc_rsp_stub_if #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_BITS      = 64
);
    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;

    // Request channel (L2 -> home node)
    logic                      req_valid;
    logic                      req_ready;
    logic [2:0]                req_coh_msg;
    logic [LINE_ADDR_BITS-1:0] req_addr;
    logic [LINE_BITS-1:0]      req_line;
    logic [WORDS_PER_LINE-1:0] req_word_mask;

    // Response channel (home node -> L2)
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [2:0]                rsp_coh_msg;
    logic [LINE_ADDR_BITS-1:0] rsp_addr;
    logic [LINE_BITS-1:0]      rsp_line;
    logic [WORDS_PER_LINE-1:0] rsp_word_mask;

    modport master (
        output req_valid, req_coh_msg, req_addr, req_line, req_word_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask
    );

    modport slave (
        input  req_valid, req_coh_msg, req_addr, req_line, req_word_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask
    );
endinterface

// File: rtl/l2_llc_rsp_stub.sv
// Single-requestor LLC stand-in: serves one L2 request at a time from a small
// word-masked line memory with per-word ownership bits, and returns the matching
// response after a fixed latency.
module l2_llc_rsp_stub #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_BITS      = 64,
    parameter int MEM_LINES      = 16,
    parameter int RSP_LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    l2_llc_rsp_stub_if.slave bus,
    output logic             busy,
    output logic [7:0]       err_cnt
);
    localparam int IDX_BITS  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
    localparam logic [3:0] LAT_INIT = 4'(RSP_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    // Request codes; the response code reuses the same index.
    typedef enum logic [2:0] {
        MSG_V     = 3'd0,
        MSG_S     = 3'd1,
        MSG_WT    = 3'd2,
        MSG_O     = 3'd3,
        MSG_WB    = 3'd4,
        MSG_ODATA = 3'd5
    } coh_msg_e;

    state_e                    state;
    logic [3:0]                wait_cnt;
    coh_msg_e                  msg_q;
    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0]      line_q;
    logic [WORDS_PER_LINE-1:0] mask_q;

    logic [WORD_BITS-1:0]      mem   [MEM_LINES][WORDS_PER_LINE];
    logic [WORDS_PER_LINE-1:0] owned [MEM_LINES];

    logic [IDX_BITS-1:0]       idx;
    logic [LINE_BITS-1:0]      rd_line;
    logic                      req_legal;
    logic                      rd_returns_data;
    logic                      wr_data;

    // Upper address bits are ignored, so aliased addresses share a line.
    assign idx             = addr_q[IDX_BITS-1:0];
    assign req_legal       = (bus.req_coh_msg <= 3'd5);
    assign rd_returns_data = (msg_q == MSG_V) || (msg_q == MSG_S) ||
                             (msg_q == MSG_O) || (msg_q == MSG_ODATA);
    assign wr_data         = (msg_q == MSG_WT) || (msg_q == MSG_WB);

    // Gather the addressed line into a flat vector for the response.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        rd_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            rd_line[i*WORD_BITS +: WORD_BITS] = mem[idx][i];
        end
    end

    // Masked line writes and ownership updates, performed only in ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the backing store is cleared by reset because a freshly reset home node must return zero data; this keeps it in flops rather than a RAM macro.
            for (int l = 0; l < MEM_LINES; l++) begin
                owned[l] <= '0;
                for (int w = 0; w < WORDS_PER_LINE; w++) begin
                    mem[l][w] <= '0;
                end
            end
        end else if (state == ACCESS) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                if (mask_q[i]) begin
                    if (wr_data) begin
                        mem[idx][i] <= line_q[i*WORD_BITS +: WORD_BITS];
                    end
                    if ((msg_q == MSG_O) || (msg_q == MSG_ODATA)) begin
                        owned[idx][i] <= 1'b1;
                    end else if (msg_q == MSG_WB) begin
                        owned[idx][i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Request/response sequencing with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state             <= IDLE;
            wait_cnt          <= '0;
            msg_q             <= MSG_V;
            addr_q            <= '0;
            line_q            <= '0;
            mask_q            <= '0;
            bus.req_ready     <= 1'b1;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_coh_msg   <= '0;
            bus.rsp_addr      <= '0;
            bus.rsp_line      <= '0;
            bus.rsp_word_mask <= '0;
            busy              <= 1'b0;
            err_cnt           <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_legal) begin
                            msg_q         <= coh_msg_e'(bus.req_coh_msg);
                            addr_q        <= bus.req_addr;
                            line_q        <= bus.req_line;
                            mask_q        <= bus.req_word_mask;
                            bus.req_ready <= 1'b0;
                            busy          <= 1'b1;
                            state         <= ACCESS;
                        end else if (err_cnt != 8'hFF) begin
                            // Illegal codes are counted and dropped without a response.
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end

                ACCESS: begin
                    bus.rsp_coh_msg   <= msg_q;
                    bus.rsp_addr      <= addr_q;
                    bus.rsp_word_mask <= mask_q;
                    bus.rsp_line      <= rd_returns_data ? rd_line : '0;
                    wait_cnt          <= LAT_INIT;
                    if (RSP_LATENCY == 0) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        state         <= WAIT;
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    // Response fields stay untouched here, so they hold until consumed.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l2_llc_rsp_stub.sv
// Scoreboard bench for l2_llc_rsp_stub: a reference model of the line memory and
// ownership bits predicts each response when the request is accepted.
module tb_l2_llc_rsp_stub;
    localparam int LAB = 28;
    localparam int WPL = 4;
    localparam int WB  = 64;
    localparam int ML  = 16;
    localparam int LAT = 2;
    localparam int LB  = WPL * WB;

    typedef logic [LB-1:0] val_t;

    typedef struct {
        logic [2:0]     msg;
        logic [LAB-1:0] addr;
        logic [LB-1:0]  line;
        logic [WPL-1:0] mask;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    l2_llc_rsp_stub_if #(.LINE_ADDR_BITS(LAB), .WORDS_PER_LINE(WPL), .WORD_BITS(WB)) bus ();

    l2_llc_rsp_stub #(
        .LINE_ADDR_BITS(LAB),
        .WORDS_PER_LINE(WPL),
        .WORD_BITS     (WB),
        .MEM_LINES     (ML),
        .RSP_LATENCY   (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    rsp_t           exp_q[$];
    logic [WB-1:0]  m_mem   [ML][WPL];
    logic [WPL-1:0] m_owned [ML];
    int             n_checks = 0;
    int             n_pass   = 0;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int l = 0; l < ML; l++) begin
            m_owned[l] = '0;
            for (int w = 0; w < WPL; w++) m_mem[l][w] = '0;
        end
        exp_q.delete();
    endtask

    // Predict the response and update the reference state for one legal request.
    task automatic model_apply(input logic [2:0] msg, input logic [LAB-1:0] addr,
                               input logic [LB-1:0] line, input logic [WPL-1:0] mask);
        rsp_t r;
        int   idx;
        idx    = int'(addr[3:0]);
        r.msg  = msg;
        r.addr = addr;
        r.mask = mask;
        r.line = '0;
        if (msg == 3'd0 || msg == 3'd1 || msg == 3'd3 || msg == 3'd5) begin
            for (int i = 0; i < WPL; i++) r.line[i*WB +: WB] = m_mem[idx][i];
        end
        for (int i = 0; i < WPL; i++) begin
            if (mask[i]) begin
                if (msg == 3'd2 || msg == 3'd4) m_mem[idx][i] = line[i*WB +: WB];
                if (msg == 3'd3 || msg == 3'd5) m_owned[idx][i] = 1'b1;
                if (msg == 3'd4)                m_owned[idx][i] = 1'b0;
            end
        end
        exp_q.push_back(r);
    endtask

    // Wait (bounded) for req_ready, take the accepting edge, and record the expectation.
    task automatic accept();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", val_t'(n < 50), val_t'(1));
        @(posedge clk);
        if (bus.req_coh_msg <= 3'd5)
            model_apply(bus.req_coh_msg, bus.req_addr, bus.req_line, bus.req_word_mask);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Caller is at a negedge; present a request and wait for it to be accepted.
    task automatic send(input logic [2:0] msg, input logic [LAB-1:0] addr,
                        input logic [LB-1:0] line, input logic [WPL-1:0] mask);
        bus.req_valid     = 1'b1;
        bus.req_coh_msg   = msg;
        bus.req_addr      = addr;
        bus.req_line      = line;
        bus.req_word_mask = mask;
        accept();
    endtask

    // Called at the first negedge after the accepting edge; counts cycles to rsp_valid.
    task automatic await_rsp(input int exp_lat);
        int n = 1;
        while (!bus.rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rsp_latency", val_t'(n), val_t'(exp_lat));
    endtask

    // Hold rsp_ready low for 'hold' cycles, compare against the scoreboard, then consume.
    task automatic finish_rsp(input int hold);
        rsp_t e;
        check("scoreboard_depth", val_t'(exp_q.size()), val_t'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            check("hold_valid", val_t'(bus.rsp_valid), val_t'(1));
            check("hold_hdr", val_t'({bus.rsp_coh_msg, bus.rsp_addr, bus.rsp_word_mask}),
                  val_t'({e.msg, e.addr, e.mask}));
            check("hold_line", bus.rsp_line, e.line);
            check("hold_req_ready", val_t'(bus.req_ready), val_t'(0));
            @(negedge clk);
        end
        check("rsp_valid", val_t'(bus.rsp_valid), val_t'(1));
        check("rsp_msg", val_t'(bus.rsp_coh_msg), val_t'(e.msg));
        check("rsp_addr", val_t'(bus.rsp_addr), val_t'(e.addr));
        check("rsp_mask", val_t'(bus.rsp_word_mask), val_t'(e.mask));
        check("rsp_line", bus.rsp_line, e.line);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", val_t'(bus.rsp_valid), val_t'(0));
        check("req_ready_back", val_t'(bus.req_ready), val_t'(1));
        check("busy_idle", val_t'(busy), val_t'(0));
    endtask

    task automatic transact(input logic [2:0] msg, input logic [LAB-1:0] addr,
                            input logic [LB-1:0] line, input logic [WPL-1:0] mask, input int hold);
        send(msg, addr, line, mask);
        await_rsp(2 + LAT);
        finish_rsp(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, val_t'(bus.req_ready), val_t'(1));
        check({tag, "_rsp_valid"}, val_t'(bus.rsp_valid), val_t'(0));
        check({tag, "_rsp_hdr"}, val_t'({bus.rsp_coh_msg, bus.rsp_addr, bus.rsp_word_mask}), val_t'(0));
        check({tag, "_rsp_line"}, bus.rsp_line, val_t'(0));
        check({tag, "_busy"}, val_t'(busy), val_t'(0));
        check({tag, "_err_cnt"}, val_t'(err_cnt), val_t'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0]  wt_line;
        logic [LB-1:0]  rnd_line;
        logic [LAB-1:0] rnd_addr;
        int             exp_err;

        bus.req_valid     = 1'b0;
        bus.req_coh_msg   = '0;
        bus.req_addr      = '0;
        bus.req_line      = '0;
        bus.req_word_mask = '0;
        bus.rsp_ready     = 1'b0;
        model_reset();

        // Reset values while reset is held.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ReqV on a cleared memory.
        transact(3'd0, 28'h5, '0, 4'hF, 0);

        // ReqWT with mask 0x5, then ReqS sees {A,0,C,0}.
        wt_line = {64'hDDDD_0000_0000_DDDD, 64'hCCCC_0000_0000_CCCC,
                   64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA};
        transact(3'd2, 28'h3, wt_line, 4'h5, 0);
        transact(3'd1, 28'h3, '0, 4'hF, 0);

        // Ownership: ReqO then ReqWB then ReqV.
        transact(3'd3, 28'h7, '0, 4'h3, 0);
        check("owned7_after_reqo", val_t'(dut.owned[7]), val_t'(m_owned[7]));
        transact(3'd4, 28'h7, val_t'(64'h1234), 4'h1, 0);
        check("owned7_after_reqwb", val_t'(dut.owned[7]), val_t'(m_owned[7]));
        transact(3'd0, 28'h7, '0, 4'hF, 0);

        // Mask 0: response still sent, memory untouched.
        transact(3'd2, 28'h3, {LB{1'b1}}, 4'h0, 0);
        transact(3'd0, 28'h3, '0, 4'hF, 0);

        // Back-pressure with a waiting request: accepted only after the handshake.
        send(3'd0, 28'h3, '0, 4'hF);
        await_rsp(2 + LAT);
        bus.req_valid     = 1'b1;
        bus.req_coh_msg   = 3'd1;
        bus.req_addr      = 28'h7;
        bus.req_line      = '0;
        bus.req_word_mask = 4'hF;
        finish_rsp(10);
        accept();
        check("b2b_busy", val_t'(busy), val_t'(1));
        await_rsp(2 + LAT);
        finish_rsp(0);

        // Illegal codes 6 and 7, then 300 more: no response, counter saturates.
        exp_err = 0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 302; i++) begin
            bus.req_coh_msg = (i % 2 == 0) ? 3'd6 : 3'd7;
            bus.req_addr    = LAB'(i);
            @(posedge clk);
            @(negedge clk);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            check("illegal_err_cnt", val_t'(err_cnt), val_t'(exp_err));
            check("illegal_no_rsp", val_t'(bus.rsp_valid), val_t'(0));
            check("illegal_req_ready", val_t'(bus.req_ready), val_t'(1));
        end
        bus.req_valid = 1'b0;
        check("illegal_scoreboard", val_t'(exp_q.size()), val_t'(0));

        // Reset asserted during WAIT after a ReqWT; the write is lost with the memory.
        send(3'd2, 28'h9, {LB{1'b1}}, 4'hF);
        @(negedge clk);
        check("wait_busy", val_t'(busy), val_t'(1));
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        transact(3'd0, 28'h9, '0, 4'hF, 0);

        // Aliasing: 0x13 and 0x03 share line 3.
        transact(3'd2, 28'h13, {64'h44, 64'h33, 64'h22, 64'h11}, 4'hF, 0);
        transact(3'd0, 28'h03, '0, 4'hF, 0);

        // Random legal traffic with random back-pressure.
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < LB / 32; k++) rnd_line[k*32 +: 32] = $urandom;
            rnd_addr = LAB'($urandom);
            transact(3'($urandom_range(0, 5)), rnd_addr, rnd_line,
                     4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
        for (int l = 0; l < ML; l++) begin
            check("owned_final", val_t'(dut.owned[l]), val_t'(m_owned[l]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/l2_llc_rsp_stub.md
Name: l2_llc_rsp_stub

Overview:
- Single-requestor home-node responder for the L2's request/response channel pair. Accepts L2 outbound requests (ReqV, ReqS, ReqWT, ReqO, ReqWB, ReqOdata) and returns the matching response on the L2 response-in channel.
- Backed by a small word-masked line memory and per-word ownership tracking.
- Used as the LLC stand-in for standalone L2 bring-up, and as the protocol-level reference for the response side.

Parameters:
- LINE_ADDR_BITS, 28, request/response line-address width
- WORDS_PER_LINE, 4, words per line
- WORD_BITS, 64, bits per word
- MEM_LINES, 16, backing lines (power of 2); index = addr[log2(MEM_LINES)-1:0]
- RSP_LATENCY, 2, wait cycles between memory access and response valid (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_coh_msg  in  3  0 ReqV, 1 ReqS, 2 ReqWT, 3 ReqO, 4 ReqWB, 5 ReqOdata, 6-7 illegal
- req_addr  in  LINE_ADDR_BITS  line address
- req_line  in  WORDS_PER_LINE*WORD_BITS  write data, word i at bits [i*WORD_BITS +: WORD_BITS]
- req_word_mask  in  WORDS_PER_LINE  words targeted
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_coh_msg  out  3  0 RspV, 1 RspS, 2 RspWTack, 3 RspO, 4 RspWBack, 5 RspOdata
- rsp_addr  out  LINE_ADDR_BITS  echoed request address
- rsp_line  out  WORDS_PER_LINE*WORD_BITS  read data
- rsp_word_mask  out  WORDS_PER_LINE  echoed request mask
- busy  out  1  FSM not in IDLE
- err_cnt  out  8  illegal-request count, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; all memory words to 0; all owned bits to 0.
  - req_ready=1, rsp_valid=0, rsp_* data=0, busy=0, err_cnt=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch coh_msg/addr/line/mask.
  - If coh_msg is legal, go to ACCESS. If illegal, err_cnt+=1 (saturating at 255), stay in IDLE, send no response.
- ACCESS: one cycle; req_ready=0. Per-message action, word i participating only if mask[i]=1:
  - ReqV, ReqS: read the full line into rsp_line; mask echoed; no ownership change.
  - ReqWT: write the masked words; rsp_line=0.
  - ReqO: set owned[i]; rsp_line = the current line.
  - ReqOdata: set owned[i]; rsp_line = the current line.
  - ReqWB: write the masked words and clear owned[i]; rsp_line=0.
- ACCESS exit: load the wait counter with RSP_LATENCY. If RSP_LATENCY=0, go directly to RESP; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 1.
- Latency: request accept to rsp_valid = 2+RSP_LATENCY cycles.
- RESP:
  - rsp_valid=1 with rsp_coh_msg = latched req code (same index).
  - All rsp_* fields held stable until rsp_ready.
  - On rsp_valid&rsp_ready, drop rsp_valid next cycle and return to IDLE.
- Throughput: one outstanding request; req_ready low in ACCESS, WAIT and RESP. Back-to-back: the next request is accepted the cycle after the handshake.
- Read-after-write: ACCESS reads see all prior completed writes. A same-cycle read/write within one ACCESS cannot occur.
- Aliasing: address bits above the index are ignored; addresses differing only in upper bits share a line.
- Masks:
  - Mask 0 is legal: no memory/ownership change, response still sent.
  - ReqWB on a non-owned word still writes it.
- busy = (state != IDLE).
- Reset mid-transaction: drop everything and return to the reset values immediately; the in-flight response is lost.

Test Plan:
- Reset then ReqV addr 0x5, mask 0xF, RSP_LATENCY=2 -> rsp_valid 4 cycles after accept; RspV(0), line all zero, mask 0xF, addr 0x5.
- ReqWT addr 0x3, mask 0x5, words {A,B,C,D} -> RspWTack(2). Then ReqS addr 0x3 mask 0xF -> RspS line {A,0,C,0}.
- ReqO addr 0x7 mask 0x3 -> RspO(3); owned[7]=0x3. ReqWB addr 0x7 mask 0x1 with word0=0x1234 -> RspWBack(4), owned[7]=0x2. ReqV -> word0=0x1234.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and all fields stable, req_ready=0 throughout. Request presented meanwhile is accepted only the cycle after the handshake.
- Inject coh_msg 6 then 7, each once, plus 300 illegal requests -> no rsp_valid ever, req_ready stays 1, err_cnt saturates at 255.
- Assert rst low during WAIT after a ReqWT (write already performed in ACCESS) -> outputs at reset values asynchronously; subsequent ReqV returns zero data.
- Aliasing: ReqWT addr 0x13 then ReqV addr 0x03 with MEM_LINES=16 -> data from 0x13 returned.
